// File: rtl/lcd_figure_sequencer.sv
// Mood/need figure sequencer feeding the HD44780 custom-character LCD.
// Optional macro LCD_SEQ_PRIORITY_EN: critical-health override.
module lcd_figure_sequencer #(
  parameter int STAT_W      = 7,
  parameter int LOW_THR     = 30,
  parameter int HIGH_THR    = 70,
`ifdef LCD_SEQ_PRIORITY_EN
  parameter int CRIT_THR    = 10,
`endif
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stats_valid,
  input  logic [STAT_W-1:0] stat_energy,
  input  logic [STAT_W-1:0] stat_fun,
  input  logic [STAT_W-1:0] stat_food,
  input  logic [STAT_W-1:0] stat_health,
  input  logic              frame_done,
  output logic [4:0]        select_figures,
  output logic              ready_o,
  output logic              fig_update
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SHOW,
    ADVANCE
  } state_t;

  localparam logic [STAT_W-1:0] LOW_T  = STAT_W'(LOW_THR);
  localparam logic [STAT_W-1:0] HIGH_T = STAT_W'(HIGH_THR);
`ifdef LCD_SEQ_PRIORITY_EN
  localparam logic [STAT_W-1:0] CRIT_T = STAT_W'(CRIT_THR);
`endif
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t            state;
  logic [STAT_W-1:0] s_energy;
  logic [STAT_W-1:0] s_fun;
  logic [STAT_W-1:0] s_food;
  logic [STAT_W-1:0] s_health;
  logic [7:0]        hold_cnt;
  logic [1:0]        ptr;

  logic [3:0] low;
  logic       high_all;
  logic       found;
  logic [1:0] cand;
  logic [1:0] nxt_ptr;
  logic [1:0] nxt_fig1;
  logic [2:0] nxt_fig2;
  logic [4:0] nxt_sel;

  always_comb begin
    low = {s_health < LOW_T, s_food < LOW_T,
           s_fun < LOW_T, s_energy < LOW_T};
    high_all = (s_energy >= HIGH_T) && (s_fun >= HIGH_T)
            && (s_food >= HIGH_T) && (s_health >= HIGH_T);
    if (|low)
      nxt_fig1 = 2'b01;
    else if (high_all)
      nxt_fig1 = 2'b00;
    else
      nxt_fig1 = 2'b11;
    // Round-robin from the slot after the last shown need.
    found   = 1'b0;
    cand    = ptr;
    nxt_ptr = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && low[cand]) begin
        found   = 1'b1;
        nxt_ptr = cand;
      end
    end
    nxt_fig2 = found ? {1'b0, nxt_ptr} : 3'b100;
`ifdef LCD_SEQ_PRIORITY_EN
    if (s_health < CRIT_T) begin
      nxt_fig1 = 2'b01;
      nxt_fig2 = 3'b011;
      nxt_ptr  = 2'd3;
    end
`endif
    nxt_sel = {nxt_fig1, nxt_fig2};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      select_figures <= 5'b11100;
      ready_o        <= 1'b0;
      fig_update     <= 1'b0;
      hold_cnt       <= '0;
      ptr            <= 2'd3;
      s_energy       <= '0;
      s_fun          <= '0;
      s_food         <= '0;
      s_health       <= '0;
    end else begin
      fig_update <= 1'b0;
      if (stats_valid) begin
        s_energy <= stat_energy;
        s_fun    <= stat_fun;
        s_food   <= stat_food;
        s_health <= stat_health;
      end
      unique case (state)
        IDLE: begin
          if (stats_valid)
            state <= EVAL;
        end
        EVAL: begin
          select_figures <= nxt_sel;
          fig_update     <= (nxt_sel != select_figures);
          ptr            <= nxt_ptr;
          ready_o        <= 1'b1;
          state          <= SHOW;
        end
        SHOW: begin
          if (frame_done) begin
            if (hold_cnt == HOLD_LAST)
              state <= ADVANCE;
            else
              hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ADVANCE: begin
          hold_cnt <= '0;
          state    <= EVAL;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
